// File: rtl/muladd_pkg.sv
// Stage record and range-check helpers shared by the muladd_pipe slice.
// Optional feature macro: MULADD_RANGE_CHK_EN (adds the pipelined range_err flag).
package muladd_pkg;

    localparam int MULADD_N = 5;
    localparam int MULADD_M = 3;
    localparam int ACC_W    = MULADD_N + MULADD_M;

    typedef struct packed {
        logic                valid;
        logic [MULADD_N-1:0] merchant;
        logic [MULADD_M-1:0] divisor;
        logic [ACC_W-1:0]    acc;
`ifdef MULADD_RANGE_CHK_EN
        logic                err;
`endif
    } stage_t;

    // Builds the record entering the first stage: accumulator starts at the addend.
    function automatic stage_t load_stage(input logic                valid,
                                          input logic [MULADD_N-1:0] merchant,
                                          input logic [MULADD_M-1:0] divisor,
                                          input logic [MULADD_M-1:0] remainder);
        stage_t s;
        s          = '0;
        s.valid    = valid;
        s.merchant = merchant;
        s.divisor  = divisor;
        s.acc      = ACC_W'(remainder);
`ifdef MULADD_RANGE_CHK_EN
        s.err      = (remainder >= divisor);
`endif
        return s;
    endfunction

`ifdef MULADD_RANGE_CHK_EN
    // Not a legal divider output pair: result wider than N bits, or remainder >= divisor.
    function automatic logic range_err_of(input stage_t s);
        return s.err | (|s.acc[ACC_W-1:MULADD_N]);
    endfunction
`endif

endpackage

// File: rtl/muladd_stage.sv
// One shift-and-add step: adds merchant << K when divisor bit K is set.
// Data only loads on a valid record so bubbles leave the stage untouched.
module muladd_stage
    import muladd_pkg::*;
#(
    parameter int K = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t stage_i,
    output stage_t stage_o
);

    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        stage_d = stage_i;
        if (stage_i.divisor[K]) begin
            stage_d.acc = stage_i.acc + (ACC_W'(stage_i.merchant) << K);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (stage_i.valid) begin
            stage_q <= stage_d;
        end else begin
            stage_q.valid <= 1'b0;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/muladd_pipe.sv
// Pipelined multiply-add rebuilding a dividend: product = merchant*divisor + remainder.
// Optional feature macro: MULADD_RANGE_CHK_EN adds output range_err.
module muladd_pipe
    import muladd_pkg::*;
#(
    parameter int N = MULADD_N,
    parameter int M = MULADD_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_enable,
    input  logic [N-1:0] merchant,
    input  logic [M-1:0] divisor,
    input  logic [M-1:0] remainder,
    output logic         result_ready,
`ifdef MULADD_RANGE_CHK_EN
    output logic         range_err,
`endif
    output logic [N+M-1:0] product
);

    // pipe[k] feeds stage k; pipe[M] is the registered output of the last stage.
    stage_t pipe [0:M];

    assign pipe[0] = load_stage(data_enable, merchant, divisor, remainder);

    for (genvar k = 0; k < M; k++) begin : g_stage
        muladd_stage #(
            .K(k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .stage_i(pipe[k]),
            .stage_o(pipe[k+1])
        );
    end

    assign result_ready = pipe[M].valid;
    assign product      = pipe[M].acc;

`ifdef MULADD_RANGE_CHK_EN
    // Flag is derived from registered state, so it holds and resets with the result.
    assign range_err = range_err_of(pipe[M]);
`endif

    logic unused_tail;
    assign unused_tail = ^{pipe[M].merchant, pipe[M].divisor};

endmodule
